// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//   Shares one 4-digit multiplexed 7-segment display between two requesters
//   (0 = counter, 1 = message). Ownership changes only on scan-frame
//   boundaries, so one owner's data is never mixed into another's frame.
//   An owner keeps the display for at least HOLD_FRAMES complete frames while
//   it keeps requesting. Ties from IDLE are broken round-robin.
//
// Parameters
//   HOLD_FRAMES : minimum frames per ownership (<= 2^HOLD_W-1)
//   HOLD_W      : hold counter width
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   tick        : one-cycle scan enable from the clock divider
//   req0, req1  : display requests
//   data0,data1 : four nibbles each, [3:0] = rightmost digit
//   gnt         : one-hot grant, 00 = idle
//   AN          : active-low digit enables, AN[0] = rightmost
//   digit       : nibble for the segment decoder
//
// Optional feature
//   LEADING_ZERO_BLANK_EN : when defined, positions 3..1 whose nibble and all
//   higher nibbles are zero are blanked (AN stays high). Position 0 is always
//   driven while owned.
// -----------------------------------------------------------------------------
module display_arbiter #(
    parameter int HOLD_FRAMES = 250,
    parameter int HOLD_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic [3:0]  AN,
    output logic [3:0]  digit
);

    // State encoding doubles as the one-hot grant.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);

    state_t              state, state_nxt;
    logic [1:0]          idx;
    logic [1:0]          idx_nxt;
    logic                boundary;
    logic [HOLD_W-1:0]   hold, hold_nxt;
    logic                ptr, ptr_nxt;       // last requester served
    logic [15:0]         frame, frame_nxt;
    logic [3:0]          an_nxt;
    logic [3:0]          digit_nxt;
    logic [3:0]          upper_zero;

    assign idx_nxt  = idx + 2'd1;
    assign boundary = tick && (idx == 2'd3);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next-state logic: arbitration only at a frame boundary
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        ptr_nxt   = ptr;
        if (boundary) begin
            case (state)
                IDLE: begin
                    // Requester 0 wins a tie only if 1 was served last.
                    if (req0 && (!req1 || ptr)) begin
                        state_nxt = OWN0;
                        hold_nxt  = HOLD_LOAD;
                        ptr_nxt   = 1'b0;
                    end else if (req1) begin
                        state_nxt = OWN1;
                        hold_nxt  = HOLD_LOAD;
                        ptr_nxt   = 1'b1;
                    end
                end
                OWN0: begin
                    if (hold != '0 && req0) begin
                        hold_nxt = hold - 1'b1;
                    end else if (req1) begin
                        state_nxt = OWN1;
                        hold_nxt  = HOLD_LOAD;
                        ptr_nxt   = 1'b1;
                    end else if (req0) begin
                        hold_nxt  = HOLD_LOAD;   // re-keep: fresh hold period
                        ptr_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                OWN1: begin
                    if (hold != '0 && req1) begin
                        hold_nxt = hold - 1'b1;
                    end else if (req0) begin
                        state_nxt = OWN0;
                        hold_nxt  = HOLD_LOAD;
                        ptr_nxt   = 1'b0;
                    end else if (req1) begin
                        hold_nxt  = HOLD_LOAD;
                        ptr_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame data is captured only at a boundary so a frame is never torn.
    always_comb begin
        frame_nxt = frame;
        if (boundary) begin
            case (state_nxt)
                OWN0:    frame_nxt = data0;
                OWN1:    frame_nxt = data1;
                default: frame_nxt = 16'h0000;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. The display registers are loaded on each tick from the
    // post-tick index and frame, so the position shown after a boundary tick
    // is digit 0 of the newly latched frame.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt = state;
    end

    always_comb begin
        upper_zero[0] = 1'b0;
        upper_zero[1] = (frame_nxt[15:4]  == 12'h000);
        upper_zero[2] = (frame_nxt[15:8]  == 8'h00);
        upper_zero[3] = (frame_nxt[15:12] == 4'h0);
    end

    always_comb begin
        an_nxt    = AN;
        digit_nxt = digit;
        if (tick) begin
            if (state_nxt == IDLE) begin
                an_nxt    = 4'b1111;
                digit_nxt = 4'h0;
            end else begin
                digit_nxt = frame_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                if (upper_zero[idx_nxt]) an_nxt = 4'b1111;
                else                     an_nxt = ~(4'b0001 << idx_nxt);
`else
                an_nxt    = ~(4'b0001 << idx_nxt);
`endif
            end
        end
    end

`ifndef LEADING_ZERO_BLANK_EN
    // Blanking is compiled out; the leading-zero flags are intentionally idle.
    logic unused_upper_zero;
    assign unused_upper_zero = ^upper_zero;
`endif

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= 2'd0;
            hold  <= '0;
            ptr   <= 1'b1;      // requester 0 wins the first tie
            frame <= 16'h0000;
            AN    <= 4'b1111;
            digit <= 4'h0;
        end else begin
            if (tick) idx <= idx_nxt;
            hold  <= hold_nxt;
            ptr   <= ptr_nxt;
            frame <= frame_nxt;
            AN    <= an_nxt;
            digit <= digit_nxt;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//   Directed bench for display_arbiter with HOLD_FRAMES=2 and a tick every
//   4 clocks. A vector table drives one tick per record and checks gnt/AN/digit
//   on the cycle after the tick; short hand-written sequences cover the
//   multi-cycle corner cases (tie alternation, mid-frame drop, reset with tick,
//   leading-zero handling).
// -----------------------------------------------------------------------------
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        reset, tick, req0, req1;
    logic [15:0] data0, data1;
    logic [1:0]  gnt;
    logic [3:0]  AN, digit;

    int checks = 0;
    int errors = 0;

    display_arbiter #(.HOLD_FRAMES(2), .HOLD_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt(gnt), .AN(AN), .digit(digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1;
        logic [15:0] d0, d1;
        logic [1:0]  g;
        logic [3:0]  an, dg;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic r0, logic r1, logic [15:0] d0, logic [15:0] d1,
                                logic [1:0] g, logic [3:0] an, logic [3:0] dg);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
        v.g = g; v.an = an; v.dg = dg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [1:0] g,
                           input logic [3:0] an, input logic [3:0] dg);
        chk({name, ".gnt"},   {14'd0, gnt}, {14'd0, g});
        chk({name, ".AN"},    {12'd0, AN},  {12'd0, an});
        chk({name, ".digit"}, {12'd0, digit}, {12'd0, dg});
    endtask

    // Three quiet cycles then a one-cycle tick; returns on the negedge after
    // the ticked posedge, i.e. the cycle whose outputs reflect that tick.
    task automatic tk();
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; req0 = 1'b0; req1 = 1'b0;
        data0 = 16'h0000; data1 = 16'h0000;

        // Table: own 0 (hold 2 frames, re-keep, mid-frame data change), then
        // hand over to 1 and back.
        tbl[0]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b00, 4'b1111, 4'h0);
        tbl[1]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b00, 4'b1111, 4'h0);
        tbl[2]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b00, 4'b1111, 4'h0);
        tbl[3]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b01, 4'b1110, 4'h4);
        tbl[4]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b01, 4'b1101, 4'h3);
        tbl[5]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b01, 4'b1011, 4'h2);
        tbl[6]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b01, 4'b0111, 4'h1);
        tbl[7]  = mk(1, 0, 16'h1234, 16'hABCD, 2'b01, 4'b1110, 4'h4);
        tbl[8]  = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b1101, 4'h3);
        tbl[9]  = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b1011, 4'h2);
        tbl[10] = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b0111, 4'h1);
        tbl[11] = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b1110, 4'h8);
        tbl[12] = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b1101, 4'h7);
        tbl[13] = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b1011, 4'h6);
        tbl[14] = mk(1, 0, 16'h5678, 16'hABCD, 2'b01, 4'b0111, 4'h5);
        tbl[15] = mk(1, 1, 16'h5678, 16'hABCD, 2'b01, 4'b1110, 4'h8);
        tbl[16] = mk(1, 1, 16'h5678, 16'hABCD, 2'b01, 4'b1101, 4'h7);
        tbl[17] = mk(1, 1, 16'h5678, 16'hABCD, 2'b01, 4'b1011, 4'h6);
        tbl[18] = mk(1, 1, 16'h5678, 16'hABCD, 2'b01, 4'b0111, 4'h5);
        tbl[19] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b1110, 4'hD);
        tbl[20] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b1101, 4'hC);
        tbl[21] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b1011, 4'hB);
        tbl[22] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b0111, 4'hA);
        tbl[23] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b1110, 4'hD);
        tbl[24] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b1101, 4'hC);
        tbl[25] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b1011, 4'hB);
        tbl[26] = mk(1, 1, 16'h5678, 16'hABCD, 2'b10, 4'b0111, 4'hA);
        tbl[27] = mk(1, 1, 16'h5678, 16'hABCD, 2'b01, 4'b1110, 4'h8);

        // Reset state, sampled while reset is still held.
        repeat (2) @(negedge clk);
        chk_out("reset", 2'b00, 4'b1111, 4'h0);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            data0 = tbl[i].d0; data1 = tbl[i].d1;
            tk();
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].an, tbl[i].dg);
        end

        // Both requesting from IDLE: 0 first, then alternate every 2 frames.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h1111; data1 = 16'h2222;
        repeat (3) tk();
        chk("tie.pre", {14'd0, gnt}, 16'h0000);
        tk(); chk("tie.f0", {14'd0, gnt}, 16'h0001);
        repeat (4) tk(); chk("tie.f1", {14'd0, gnt}, 16'h0001);
        repeat (4) tk(); chk("tie.f2", {14'd0, gnt}, 16'h0002);
        repeat (4) tk(); chk("tie.f3", {14'd0, gnt}, 16'h0002);
        repeat (4) tk(); chk("tie.f4", {14'd0, gnt}, 16'h0001);

        // Owner 0 drops its request mid-frame: frame completes, then IDLE.
        do_reset();
        req0 = 1'b1; req1 = 1'b0; data0 = 16'h1234;
        repeat (4) tk();
        tk();
        chk_out("drop.pos1", 2'b01, 4'b1101, 4'h3);
        @(negedge clk);
        req0 = 1'b0;
        tk(); chk_out("drop.pos2", 2'b01, 4'b1011, 4'h2);
        tk(); chk_out("drop.pos3", 2'b01, 4'b0111, 4'h1);
        tk(); chk_out("drop.idle", 2'b00, 4'b1111, 4'h0);

        // Reset coinciding with a tick during OWN1.
        do_reset();
        req0 = 1'b0; req1 = 1'b1; data1 = 16'h9876;
        repeat (4) tk();
        chk("rt.own1", {14'd0, gnt}, 16'h0002);
        tk();
        repeat (2) @(negedge clk);
        reset = 1'b1; tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; tick = 1'b0;
        chk_out("rt.reset", 2'b00, 4'b1111, 4'h0);
        // Index restarted at 0: exactly four ticks to the first boundary.
        repeat (3) tk();
        chk("rt.idx3", {14'd0, gnt}, 16'h0000);
        tk();
        chk_out("rt.regrant", 2'b10, 4'b1110, 4'h6);

        // Leading-zero handling.
        do_reset();
        req0 = 1'b1; req1 = 1'b0; data0 = 16'h0040;
        repeat (4) tk();
`ifdef LEADING_ZERO_BLANK_EN
        chk_out("lz.p0", 2'b01, 4'b1110, 4'h0);
        tk(); chk_out("lz.p1", 2'b01, 4'b1101, 4'h4);
        tk(); chk("lz.p2.AN", {12'd0, AN}, 16'h000F);
        data0 = 16'h0000;
        tk(); chk("lz.p3.AN", {12'd0, AN}, 16'h000F);
        tk(); chk_out("z.p0", 2'b01, 4'b1110, 4'h0);
        tk(); chk("z.p1.AN", {12'd0, AN}, 16'h000F);
        tk(); chk("z.p2.AN", {12'd0, AN}, 16'h000F);
        tk(); chk("z.p3.AN", {12'd0, AN}, 16'h000F);
`else
        chk_out("lz.p0", 2'b01, 4'b1110, 4'h0);
        tk(); chk_out("lz.p1", 2'b01, 4'b1101, 4'h4);
        tk(); chk_out("lz.p2", 2'b01, 4'b1011, 4'h0);
        data0 = 16'h0000;
        tk(); chk_out("lz.p3", 2'b01, 4'b0111, 4'h0);
        tk(); chk_out("z.p0", 2'b01, 4'b1110, 4'h0);
        tk(); chk_out("z.p1", 2'b01, 4'b1101, 4'h0);
        tk(); chk_out("z.p2", 2'b01, 4'b1011, 4'h0);
        tk(); chk_out("z.p3", 2'b01, 4'b0111, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_FRAMES, default 250, giving the minimum number of complete scan frames one owner keeps the display before rearbitration.
REQ-002 The block SHALL have parameter HOLD_W, default 8, giving the hold counter width; HOLD_FRAMES SHALL be at most 2^HOLD_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: one-cycle scan enable from the clock divider.
REQ-006 The block SHALL have ports req0 and req1, input, 1 bit each: display request from requester 0 (counter) and requester 1 (message).
REQ-007 The block SHALL have ports data0 and data1, input, 16 bits each: four BCD/hex nibbles, [3:0] = rightmost digit.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot registered grant; 00 means idle.
REQ-009 The block SHALL have port AN, output, 4 bits: active-low digit enables; AN[0] = rightmost.
REQ-010 The block SHALL have port digit, output, 4 bits: nibble for the segment decoder.

Function
REQ-011 The 2-bit scan index SHALL advance by one on each clk where tick=1 and wrap 3->0; it is unaffected by ownership.
REQ-012 A frame boundary SHALL be a tick with scan index 3; all arbitration, hold updates and data latching occur only there.
REQ-013 The state machine SHALL have states IDLE, OWN0 and OWN1; gnt SHALL be 00, 01 and 10 respectively.
REQ-014 At a boundary in OWNx with the hold counter nonzero and reqx=1, the block SHALL stay in OWNx and decrement the hold counter.
REQ-015 At a boundary in OWNx with the hold counter zero or reqx=0, the block SHALL grant the other requester if it requests, else keep x if reqx=1, else go to IDLE.
REQ-016 At a boundary in IDLE, the block SHALL grant the single requester; with both requesting, it SHALL grant the one not served last (round-robin pointer).
REQ-017 On every new grant the hold counter SHALL load HOLD_FRAMES-1 and the pointer SHALL record the new owner; re-keeping x SHALL also reload it.
REQ-018 At each boundary the block SHALL latch the next owner's 16-bit data into a frame register; displayed data SHALL not change mid-frame.
REQ-019 A request dropped mid-frame SHALL NOT abort the frame; there is no preemption.
REQ-020 Outputs SHALL be registered: on the cycle after a tick, AN SHALL have exactly one low bit, at the current index, and digit SHALL equal frame_reg nibble[index].
REQ-021 In IDLE, AN SHALL be 4'b1111 and digit SHALL be 4'h0.
REQ-022 Grant latency SHALL be: gnt updates on the clk cycle after the boundary tick; worst case one frame plus one cycle after req rises.
REQ-023 A tick and reset in the same cycle SHALL resolve in favour of reset.

Reset
REQ-024 While reset=1 at a clk edge, the block SHALL set scan index 0, state IDLE, gnt=00, AN=4'b1111, digit=4'h0, hold counter 0, pointer to requester 1 (so requester 0 wins first tie), and frame register 0.
REQ-025 Reset mid-frame SHALL discard the ownership in progress; arbitration SHALL resume at the first boundary after release.

Configuration
REQ-026 The block SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-027 With LEADING_ZERO_BLANK_EN defined, digit positions 3..1 whose nibble and all higher nibbles in frame_reg are zero SHALL keep AN high; position 0 SHALL never be blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, all four positions SHALL be driven while owned.

Verification (HOLD_FRAMES=2, tick every 4 clk)
REQ-029 The bench SHALL cover: reset, req0=1, data0=16'h1234 -> gnt=01 one cycle after first boundary tick; next frame AN scans 1110,1101,1011,0111 with digit 4,3,2,1.
REQ-030 The bench SHALL cover: both requesting from IDLE after reset -> gnt=01; after 2 frames gnt=10; after 2 more gnt=01 (alternation).
REQ-031 The bench SHALL cover: owner 0 drops req0 mid-frame with req1=0 -> frame completes with latched data, then gnt=00, AN=1111.
REQ-032 The bench SHALL cover: data0 changes 16'h1234->16'h5678 mid-frame -> digits stay 4,3,2,1 until the next boundary, then 8,7,6,5.
REQ-033 The bench SHALL cover: reset asserted with a tick during OWN1 -> next cycle gnt=00, AN=1111, digit=0, index 0.
REQ-034 The bench SHALL cover, with LEADING_ZERO_BLANK_EN: data0=16'h0040 -> AN[3] and AN[2] never low, positions 1 and 0 show 4 and 0; data0=16'h0000 -> only AN[0] is ever low, showing 0.
